// File: rtl/sdram_pkg.sv
// Shared types and defaults for the SDRAM front-end arbiter.
// Widths match the sdram_controller ports.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W       = 22;
  localparam int unsigned SDRAM_DATA_W       = 16;
  localparam int unsigned SDRAM_BUSY_ARM_CYC = 4;
  localparam int unsigned SDRAM_TIMEOUT_CYC  = 1000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StArm,
    StRun,
    StResp
  } arb_state_e;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping around to index 0.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_i) + off) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one sdram_controller front-end between
// NUM_REQ requesters, with busy tracking and timeout.
module sdram_rr_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_W       = SDRAM_ADDR_W,
  parameter int unsigned DATA_W       = SDRAM_DATA_W,
  parameter int unsigned BUSY_ARM_CYC = SDRAM_BUSY_ARM_CYC,
  parameter int unsigned TIMEOUT_CYC  = SDRAM_TIMEOUT_CYC,
  localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_rdata,
  output logic                      req_err,
  output logic [IDX_W-1:0]          grant_id,
  output logic [ADDR_W-1:0]         mc_address,
  output logic [DATA_W-1:0]         mc_write_data,
  output logic                      mc_read,
  output logic                      mc_write,
  input  logic                      mc_busy,
  input  logic [DATA_W-1:0]         mc_read_data
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYC > BUSY_ARM_CYC) ? TIMEOUT_CYC : BUSY_ARM_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid && !mc_busy) begin
          win_d   = pick_idx;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StIssue;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
              we_d    = req_we[i];
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
            end
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StArm;
      end
      StArm: begin
        if (mc_busy) begin
          cnt_d   = '0;
          state_d = StRun;
        end else if (cnt_q == CNT_W'(BUSY_ARM_CYC - 1)) begin
          // Busy never rose: the controller finished the command on its own.
          state_d = StResp;
          if (!we_q) rdata_d = mc_read_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!mc_busy) begin
          state_d = StResp;
          if (!we_q) rdata_d = mc_read_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (!we_q) rdata_d = mc_read_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        ptr_d   = IDX_W'(rr_next(32'(win_q), NUM_REQ));
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    req_ack = '0;
    if (state_q == StResp) req_ack[win_q] = 1'b1;
  end

  assign req_err       = (state_q == StResp) && err_q;
  assign req_rdata     = rdata_q;
  assign grant_id      = win_q;
  assign mc_address    = addr_q;
  assign mc_write_data = wdata_q;
  assign mc_read       = (state_q == StIssue) && !we_q;
  assign mc_write      = (state_q == StIssue) && we_q;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Randomized scoreboard bench for sdram_rr_arbiter with a behavioural
// controller and a round-robin reference model.
module tb_sdram_rr_arbiter;

  localparam int N   = 4;
  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int ARM = 4;
  localparam int TMO = 40;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   req_rdata;
  logic            req_err;
  logic [1:0]      grant_id;
  logic [AW-1:0]   mc_address;
  logic [DW-1:0]   mc_write_data;
  logic            mc_read, mc_write;
  logic            mc_busy;
  logic [DW-1:0]   mc_read_data;

  sdram_rr_arbiter #(
    .NUM_REQ      (N),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .BUSY_ARM_CYC (ARM),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ack       (req_ack),
    .req_rdata     (req_rdata),
    .req_err       (req_err),
    .grant_id      (grant_id),
    .mc_address    (mc_address),
    .mc_write_data (mc_write_data),
    .mc_read       (mc_read),
    .mc_write      (mc_write),
    .mc_busy       (mc_busy),
    .mc_read_data  (mc_read_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic          chk_lat;
  } exp_t;

  exp_t cmd_q[$];
  exp_t ack_q[$];

  int tests = 0;
  int fails = 0;
  int last_cmd_cyc = 0;
  bit stuck = 1'b0;

  // Reference model state
  int            m_ptr = 0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ctrl_mem [16];

  // Per-requester batch stimulus
  logic          b_we [N];
  logic [AW-1:0] b_addr [N];
  logic [DW-1:0] b_wdata [N];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, 32'(req_ack), 0);
    check({tag, "_err"}, 32'(req_err), 0);
    check({tag, "_rdata"}, 32'(req_rdata), 0);
    check({tag, "_grant"}, 32'(grant_id), 0);
    check({tag, "_addr"}, 32'(mc_address), 0);
    check({tag, "_wdata"}, 32'(mc_write_data), 0);
    check({tag, "_rd"}, 32'(mc_read), 0);
    check({tag, "_wr"}, 32'(mc_write), 0);
  endtask

  task automatic set_one(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    b_we[i] = we;
    b_addr[i] = a;
    b_wdata[i] = d;
  endtask

  // Predict the whole service order of a batch held until acked, then drive it.
  task automatic issue_batch(input logic [N-1:0] mask, input bit errm);
    logic [N-1:0] pend;
    int win;
    int waitc;
    exp_t e;
    pend = mask;
    while (pend != 0) begin
      win = -1;
      for (int off = 0; off < N; off++)
        if (win < 0 && pend[(m_ptr + off) % N]) win = (m_ptr + off) % N;
      pend[win] = 1'b0;
      e.idx = win;
      e.we = b_we[win];
      e.addr = b_addr[win];
      e.wdata = b_wdata[win];
      e.err = errm;
      e.chk_lat = errm;
      if (!errm) begin
        if (e.we) ref_mem[e.addr[3:0]] = e.wdata;
        else m_rdata = ref_mem[e.addr[3:0]];
      end
      e.rdata = m_rdata;
      cmd_q.push_back(e);
      ack_q.push_back(e);
      m_ptr = (win + 1) % N;
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_we[i] = b_we[i];
      req_addr[i*AW +: AW] = b_addr[i];
      req_wdata[i*DW +: DW] = b_wdata[i];
    end
    req = mask;
    waitc = 0;
    while (req != 0 && waitc < TMO + 200) begin
      @(negedge clk);
      req = req & ~req_ack;
      waitc++;
    end
    if (req != 0) begin
      tests++;
      fails++;
      $display("FAIL batch_done: pending %b expected 0", req);
      req = '0;
      cmd_q.delete();
      ack_q.delete();
    end
  endtask

  // Behavioural sdram controller: random busy profile, or stuck busy.
  initial begin
    int unsigned rise, len;
    mc_busy = 1'b0;
    mc_read_data = '0;
    for (int i = 0; i < 16; i++) ctrl_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (reset_n && (mc_read || mc_write)) begin
        if (stuck) begin
          mc_busy = 1'b1;
          while (stuck) @(negedge clk);
          mc_busy = 1'b0;
        end else begin
          if (mc_write) ctrl_mem[mc_address[3:0]] = mc_write_data;
          else mc_read_data = ctrl_mem[mc_address[3:0]];
          if ($urandom_range(0, 7) != 0) begin
            rise = $urandom_range(0, 2);
            len = $urandom_range(1, 6);
            repeat (rise) @(negedge clk);
            mc_busy = 1'b1;
            repeat (len) @(negedge clk);
            mc_busy = 1'b0;
          end
        end
      end
    end
  end

  // Command monitor
  initial begin
    bit prev_cmd;
    exp_t e;
    prev_cmd = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_cmd = 1'b0;
      end else if (mc_read || mc_write) begin
        check("cmd_exclusive", 32'(mc_read && mc_write), 0);
        check("cmd_single_cycle", 32'(prev_cmd), 0);
        last_cmd_cyc = cyc;
        if (cmd_q.size() == 0) begin
          check("cmd_unexpected", 1, 0);
        end else begin
          e = cmd_q.pop_front();
          check("cmd_we", 32'(mc_write), 32'(e.we));
          check("cmd_addr", 32'(mc_address), 32'(e.addr));
          if (e.we) check("cmd_wdata", 32'(mc_write_data), 32'(e.wdata));
        end
        prev_cmd = 1'b1;
      end else begin
        prev_cmd = 1'b0;
      end
    end
  end

  // Ack monitor
  initial begin
    bit prev_ack;
    exp_t e;
    logic [N-1:0] oh;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ack = 1'b0;
      end else if (req_ack != 0) begin
        check("ack_single_cycle", 32'(prev_ack), 0);
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 32'(req_ack), 0);
        end else begin
          e = ack_q.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          check("ack_onehot", 32'(req_ack), 32'(oh));
          check("ack_grant_id", 32'(grant_id), 32'(e.idx));
          check("ack_err", 32'(req_err), 32'(e.err));
          check("ack_rdata", 32'(req_rdata), 32'(e.rdata));
          if (e.chk_lat) check("timeout_latency", 32'(cyc - last_cmd_cyc), 32'(TMO + 2));
        end
        prev_ack = 1'b1;
      end else begin
        check("err_without_ack", 32'(req_err), 0);
        prev_ack = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < N; i++) set_one(i, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    set_one(0, 1'b1, 22'h000001, 16'hA5A5);
    issue_batch(4'b0001, 1'b0);
    set_one(2, 1'b0, 22'h000001, 16'h0000);
    issue_batch(4'b0100, 1'b0);
    set_one(3, 1'b0, 22'h000001, 16'h0000);
    issue_batch(4'b1000, 1'b0);

    for (int i = 0; i < N; i++) set_one(i, 1'b1, AW'(i + 1), DW'((i + 1) * 16'h1111));
    issue_batch(4'b1111, 1'b0);
    for (int i = 0; i < N; i++) set_one(i, 1'b0, AW'(i + 1), '0);
    issue_batch(4'b1111, 1'b0);

    set_one(2, 1'b0, 22'h000003, '0);
    issue_batch(4'b0100, 1'b0);
    set_one(3, 1'b0, 22'h000004, '0);
    set_one(0, 1'b0, 22'h000001, '0);
    issue_batch(4'b1001, 1'b0);

    stuck = 1'b1;
    set_one(1, 1'b1, 22'h000005, 16'hBEEF);
    issue_batch(4'b0010, 1'b1);
    stuck = 1'b0;
    set_one(1, 1'b0, 22'h000005, '0);
    issue_batch(4'b0010, 1'b0);
    set_one(3, 1'b0, 22'h000004, '0);
    issue_batch(4'b1000, 1'b0);

    // Abort a transaction in flight with reset.
    begin
      exp_t e;
      stuck = 1'b1;
      @(negedge clk);
      e.idx = 2;
      e.we = 1'b1;
      e.addr = 22'h000006;
      e.wdata = 16'h1234;
      e.rdata = '0;
      e.err = 1'b0;
      e.chk_lat = 1'b0;
      cmd_q.push_back(e);
      req_we[2] = 1'b1;
      req_addr[2*AW +: AW] = 22'h000006;
      req_wdata[2*DW +: DW] = 16'h1234;
      req = 4'b0100;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      req = '0;
      stuck = 1'b0;
      #1;
      check_outputs_zero("midop_reset");
      cmd_q.delete();
      ack_q.delete();
      m_ptr = 0;
      m_rdata = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
    end

    set_one(1, 1'b1, 22'h000002, 16'h5A5A);
    issue_batch(4'b0010, 1'b0);
    set_one(0, 1'b0, 22'h000002, '0);
    issue_batch(4'b0001, 1'b0);

    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < N; i++)
        set_one(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
      issue_batch(N'($urandom_range(1, 15)), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("ack_queue_drained", 32'(ack_q.size()), 0);
    check("cmd_queue_drained", 32'(cmd_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
